// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder
//  Description : Memory-side responder for the CPU instruction and data
//                ports. Both ports share one byte-lane-writable word RAM;
//                the data port also reaches a 16-byte MMIO block holding a
//                GPIO output, a free-running cycle counter and sticky
//                out-of-range error capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
   parameter logic [31:0] BAD_DATA  = 32'hDEAD_BEEF
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] addr_inst,
   input  logic [31:0] data_out_inst,
   output logic [31:0] data_in_inst,
   input  logic        en_inst,
   input  logic [3:0]  we_inst,
   input  logic [31:0] addr_data,
   input  logic [31:0] data_out_data,
   output logic [31:0] data_in_data,
   input  logic        en_data,
   input  logic [3:0]  we_data,
   output logic [31:0] gpio_out,
   output logic        mem_err
);

   localparam int unsigned ADDR_W = $clog2(MEM_WORDS);

   localparam logic [1:0] REG_GPIO     = 2'd0;
   localparam logic [1:0] REG_CYCLE    = 2'd1;
   localparam logic [1:0] REG_STATUS   = 2'd2;
   localparam logic [1:0] REG_ERR_ADDR = 2'd3;

   logic [31:0]       mem [MEM_WORDS];

   logic [ADDR_W-1:0] idx_inst;
   logic [ADDR_W-1:0] idx_data;
   logic              inst_ram_hit;
   logic              data_ram_hit;
   logic              data_mmio_hit;
   logic [1:0]        mmio_sel;
   logic              inst_err;
   logic              data_err;
   logic              inst_ram_wr;
   logic              data_ram_wr;
   logic              gpio_wr;
   logic              err_clr;
   logic [31:0]       mmio_rdata;

   logic [31:0]       data_in_inst_d, data_in_inst_q;
   logic [31:0]       data_in_data_d, data_in_data_q;
   logic [31:0]       gpio_d,         gpio_q;
   logic [31:0]       cycle_cnt_d,    cycle_cnt_q;
   logic              mem_err_d,      mem_err_q;
   logic [31:0]       err_addr_d,     err_addr_q;

   // Byte offset within a word is irrelevant: lanes come from we_* alone.
   logic              unused_addr_lsbs;
   assign unused_addr_lsbs = ^{addr_inst[1:0], addr_data[1:0]};

   // Address decode. The MMIO window is 16-byte aligned, so matching the
   // upper 28 bits selects it; RAM takes priority should the two overlap.
   assign idx_inst      = addr_inst[ADDR_W+1:2];
   assign idx_data      = addr_data[ADDR_W+1:2];
   assign inst_ram_hit  = (addr_inst[31:ADDR_W+2] == '0);
   assign data_ram_hit  = (addr_data[31:ADDR_W+2] == '0);
   assign data_mmio_hit = !data_ram_hit && (addr_data[31:4] == MMIO_BASE[31:4]);
   assign mmio_sel      = addr_data[3:2];

   assign inst_err    = en_inst && !inst_ram_hit;
   assign data_err    = en_data && !data_ram_hit && !data_mmio_hit;
   assign inst_ram_wr = en_inst && inst_ram_hit;
   assign data_ram_wr = en_data && data_ram_hit;
   assign gpio_wr     = en_data && data_mmio_hit && (mmio_sel == REG_GPIO);
   assign err_clr     = en_data && data_mmio_hit && (mmio_sel == REG_STATUS)
                        && we_data[0] && data_out_data[0];

   // MMIO read mux, sampling register state as held at the access edge
   always_comb begin
      mmio_rdata = '0;
      case (mmio_sel)
         REG_GPIO:     mmio_rdata = gpio_q;
         REG_CYCLE:    mmio_rdata = cycle_cnt_q;
         REG_STATUS:   mmio_rdata = {31'd0, mem_err_q};
         REG_ERR_ADDR: mmio_rdata = err_addr_q;
         default:      mmio_rdata = '0;
      endcase
   end

   // Next-state for read data, GPIO, cycle counter and error capture
   always_comb begin
      data_in_inst_d = data_in_inst_q;
      data_in_data_d = data_in_data_q;
      gpio_d         = gpio_q;
      cycle_cnt_d    = cycle_cnt_q + 32'd1;
      mem_err_d      = mem_err_q;
      err_addr_d     = err_addr_q;

      // Reads return the pre-write word, even on write cycles.
      if (en_inst) begin
         data_in_inst_d = inst_ram_hit ? mem[idx_inst] : BAD_DATA;
      end
      if (en_data) begin
         if (data_ram_hit) begin
            data_in_data_d = mem[idx_data];
         end else if (data_mmio_hit) begin
            data_in_data_d = mmio_rdata;
         end else begin
            data_in_data_d = BAD_DATA;
         end
      end

      if (gpio_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (we_data[i]) begin
               gpio_d[8*i +: 8] = data_out_data[8*i +: 8];
            end
         end
      end

      // A new error beats a same-cycle clear and recaptures the address;
      // the data port's address wins when both ports miss together.
      if (inst_err || data_err) begin
         mem_err_d = 1'b1;
         if (!mem_err_q || err_clr) begin
            err_addr_d = data_err ? addr_data : addr_inst;
         end
      end else if (err_clr) begin
         mem_err_d = 1'b0;
      end
   end

   // Registered state with asynchronous active-low reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_in_inst_q <= '0;
         data_in_data_q <= '0;
         gpio_q         <= '0;
         cycle_cnt_q    <= '0;
         mem_err_q      <= 1'b0;
         err_addr_q     <= '0;
      end else begin
         data_in_inst_q <= data_in_inst_d;
         data_in_data_q <= data_in_data_d;
         gpio_q         <= gpio_d;
         cycle_cnt_q    <= cycle_cnt_d;
         mem_err_q      <= mem_err_d;
         err_addr_q     <= err_addr_d;
      end
   end

   // RAM byte-lane writes; contents survive reset and no write lands while
   // reset is asserted. Data-port lanes are applied last so they win a
   // same-word, same-lane collision.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (aresetn) begin
         if (inst_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (we_inst[i]) begin
                  mem[idx_inst][8*i +: 8] <= data_out_inst[8*i +: 8];
               end
            end
         end
         if (data_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (we_data[i]) begin
                  mem[idx_data][8*i +: 8] <= data_out_data[8*i +: 8];
               end
            end
         end
      end
   end

   assign data_in_inst = data_in_inst_q;
   assign data_in_data = data_in_data_q;
   assign gpio_out     = gpio_q;
   assign mem_err      = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_responder
//  Description : Self-checking bench for cpu_mem_responder. Directed
//                scenarios plus randomized traffic checked against a
//                behavioural model of the memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

   localparam int unsigned MEM_WORDS = 1024;
   localparam logic [31:0] MMIO_BASE = 32'h0001_0000;
   localparam logic [31:0] BAD_DATA  = 32'hDEAD_BEEF;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] addr_inst, data_out_inst, data_in_inst;
   logic [31:0] addr_data, data_out_data, data_in_data;
   logic [31:0] gpio_out;
   logic        en_inst, en_data, mem_err;
   logic [3:0]  we_inst, we_data;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] ref_mem [MEM_WORDS];
   logic [31:0] ref_inst_out, ref_data_out, ref_gpio, ref_cyc, ref_err_addr;
   logic        ref_err;

   cpu_mem_responder #(
      .MEM_WORDS (MEM_WORDS),
      .MMIO_BASE (MMIO_BASE),
      .BAD_DATA  (BAD_DATA)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .addr_inst     (addr_inst),
      .data_out_inst (data_out_inst),
      .data_in_inst  (data_in_inst),
      .en_inst       (en_inst),
      .we_inst       (we_inst),
      .addr_data     (addr_data),
      .data_out_data (data_out_data),
      .data_in_data  (data_in_data),
      .en_data       (en_data),
      .we_data       (we_data),
      .gpio_out      (gpio_out),
      .mem_err       (mem_err)
   );

   always #5 aclk = ~aclk;

   task automatic idle();
      en_inst = 1'b0; we_inst = 4'h0; addr_inst = '0; data_out_inst = '0;
      en_data = 1'b0; we_data = 4'h0; addr_data = '0; data_out_data = '0;
   endtask

   task automatic set_inst(input logic en, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      en_inst = en; addr_inst = a; we_inst = we; data_out_inst = d;
   endtask

   task automatic set_data(input logic en, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      en_data = en; addr_data = a; we_data = we; data_out_data = d;
   endtask

   task automatic model_reset();
      ref_inst_out = '0; ref_data_out = '0; ref_gpio = '0;
      ref_cyc = '0; ref_err_addr = '0; ref_err = 1'b0;
   endtask

   // Apply the current inputs to the model, then run one clock edge.
   // Called at a falling edge; returns at the next falling edge.
   task automatic step();
      longint unsigned ai, ad;
      int unsigned wi, wd, sel;
      bit ram_i, ram_d, mmio_d, oor_i, oor_d, clr;
      ai     = addr_inst;
      ad     = addr_data;
      ram_i  = ai < 4 * MEM_WORDS;
      ram_d  = ad < 4 * MEM_WORDS;
      mmio_d = !ram_d && ad >= MMIO_BASE && ad < longint'(MMIO_BASE) + 16;
      wi     = int'((ai / 4) % MEM_WORDS);
      wd     = int'((ad / 4) % MEM_WORDS);
      sel    = mmio_d ? int'((ad - MMIO_BASE) / 4) : 0;
      oor_i  = en_inst && !ram_i;
      oor_d  = en_data && !ram_d && !mmio_d;
      clr    = en_data && mmio_d && sel == 2 && we_data[0] && data_out_data[0];

      if (en_inst) ref_inst_out = ram_i ? ref_mem[wi] : BAD_DATA;
      if (en_data) begin
         if (ram_d) ref_data_out = ref_mem[wd];
         else if (!mmio_d) ref_data_out = BAD_DATA;
         else if (sel == 0) ref_data_out = ref_gpio;
         else if (sel == 1) ref_data_out = ref_cyc;
         else if (sel == 2) ref_data_out = {31'd0, ref_err};
         else ref_data_out = ref_err_addr;
      end

      for (int b = 0; b < 4; b++) begin
         if (en_inst && ram_i && we_inst[b]) ref_mem[wi][8*b +: 8] = data_out_inst[8*b +: 8];
      end
      for (int b = 0; b < 4; b++) begin
         if (en_data && ram_d && we_data[b]) ref_mem[wd][8*b +: 8] = data_out_data[8*b +: 8];
         if (en_data && mmio_d && sel == 0 && we_data[b]) ref_gpio[8*b +: 8] = data_out_data[8*b +: 8];
      end

      if (oor_i || oor_d) begin
         if (!ref_err || clr) ref_err_addr = oor_d ? addr_data : addr_inst;
         ref_err = 1'b1;
      end else if (clr) begin
         ref_err = 1'b0;
      end
      ref_cyc = ref_cyc + 32'd1;

      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      idle();
      repeat (2) @(negedge aclk);
      model_reset();
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      repeat (3) @(negedge aclk);
      checks++; if (data_in_inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h expected %h", data_in_inst, 32'd0); end
      checks++; if (data_in_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected %h", data_in_data, 32'd0); end
      checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'd0); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected %b", mem_err, 1'b0); end
      model_reset();
      aresetn = 1'b1;
      set_data(1'b1, MMIO_BASE + 32'd4, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'd0) begin errors++; $display("FAIL reset_cycle_first: got %h expected %h", data_in_data, 32'd0); end
      step();
      checks++; if (data_in_data !== 32'd1) begin errors++; $display("FAIL reset_cycle_second: got %h expected %h", data_in_data, 32'd1); end
      set_data(1'b1, MMIO_BASE + 32'd12, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'd0) begin errors++; $display("FAIL reset_err_addr: got %h expected %h", data_in_data, 32'd0); end
      idle();
   endtask

   task automatic test_basic();
      set_data(1'b1, 32'h10, 4'hF, 32'h1234_5678); step();
      set_data(1'b1, 32'h10, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h1234_5678) begin errors++; $display("FAIL basic_lw: got %h expected %h", data_in_data, 32'h1234_5678); end
      idle(); step();
      checks++; if (data_in_data !== 32'h1234_5678) begin errors++; $display("FAIL basic_hold: got %h expected %h", data_in_data, 32'h1234_5678); end
      set_inst(1'b1, 32'h13, 4'h0, '0); step();
      checks++; if (data_in_inst !== 32'h1234_5678) begin errors++; $display("FAIL basic_inst_read: got %h expected %h", data_in_inst, 32'h1234_5678); end
      idle();
   endtask

   task automatic test_byte_lanes();
      set_data(1'b1, 32'h40, 4'hF, 32'h1122_3344); step();
      set_data(1'b1, 32'h40, 4'b0010, 32'hAABB_CCDD); step();
      checks++; if (data_in_data !== 32'h1122_3344) begin errors++; $display("FAIL lane_read_first: got %h expected %h", data_in_data, 32'h1122_3344); end
      set_data(1'b1, 32'h40, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h1122_CC44) begin errors++; $display("FAIL lane_merge: got %h expected %h", data_in_data, 32'h1122_CC44); end
      idle();
      set_inst(1'b1, 32'h40, 4'b1000, 32'h99FF_FFFF); step();
      set_inst(1'b1, 32'h40, 4'h0, '0); step();
      checks++; if (data_in_inst !== 32'h9922_CC44) begin errors++; $display("FAIL lane_inst_write: got %h expected %h", data_in_inst, 32'h9922_CC44); end
      idle();
   endtask

   task automatic test_dual_port();
      set_inst(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
      set_data(1'b1, 32'h20, 4'b0011, 32'h0000_0000); step();
      idle();
      set_data(1'b1, 32'h20, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'hFFFF_0000) begin errors++; $display("FAIL dual_collision: got %h expected %h", data_in_data, 32'hFFFF_0000); end
      set_inst(1'b1, 32'h20, 4'h0, '0);
      set_data(1'b1, 32'h20, 4'hF, 32'h0102_0304); step();
      checks++; if (data_in_inst !== 32'hFFFF_0000) begin errors++; $display("FAIL dual_read_old: got %h expected %h", data_in_inst, 32'hFFFF_0000); end
      set_inst(1'b1, 32'h24, 4'hF, 32'hA5A5_A5A5);
      set_data(1'b1, 32'h28, 4'hF, 32'h5A5A_5A5A); step();
      set_inst(1'b1, 32'h28, 4'h0, '0);
      set_data(1'b1, 32'h24, 4'h0, '0); step();
      checks++; if (data_in_inst !== 32'h5A5A_5A5A) begin errors++; $display("FAIL dual_split_inst: got %h expected %h", data_in_inst, 32'h5A5A_5A5A); end
      checks++; if (data_in_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dual_split_data: got %h expected %h", data_in_data, 32'hA5A5_A5A5); end
      idle();
      set_data(1'b1, 32'h20, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h0102_0304) begin errors++; $display("FAIL dual_new_word: got %h expected %h", data_in_data, 32'h0102_0304); end
      idle();
   endtask

   task automatic test_mmio();
      apply_reset();
      repeat (100) step();
      set_data(1'b1, MMIO_BASE + 32'd4, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'd100) begin errors++; $display("FAIL mmio_cycle_100: got %0d expected %0d", data_in_data, 100); end
      set_data(1'b1, MMIO_BASE, 4'b0001, 32'h0000_005A); step();
      checks++; if (gpio_out !== 32'h0000_005A) begin errors++; $display("FAIL mmio_gpio_write: got %h expected %h", gpio_out, 32'h0000_005A); end
      set_data(1'b1, MMIO_BASE, 4'b0100, 32'hFFFF_FFFF); step();
      checks++; if (gpio_out !== 32'h00FF_005A) begin errors++; $display("FAIL mmio_gpio_lane: got %h expected %h", gpio_out, 32'h00FF_005A); end
      set_data(1'b1, MMIO_BASE, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h00FF_005A) begin errors++; $display("FAIL mmio_gpio_read: got %h expected %h", data_in_data, 32'h00FF_005A); end
      set_data(1'b1, MMIO_BASE + 32'd4, 4'hF, 32'h0); step();
      checks++; if (data_in_data !== ref_data_out) begin errors++; $display("FAIL mmio_cycle_wr_ignored: got %h expected %h", data_in_data, ref_data_out); end
      set_data(1'b1, MMIO_BASE + 32'd4, 4'h0, '0); step();
      checks++; if (data_in_data !== ref_data_out) begin errors++; $display("FAIL mmio_cycle_continues: got %h expected %h", data_in_data, ref_data_out); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mmio_no_err: got %b expected %b", mem_err, 1'b0); end
      idle();
   endtask

   task automatic test_errors();
      set_inst(1'b1, 32'h0002_0000, 4'h0, '0); step();
      idle();
      checks++; if (data_in_inst !== BAD_DATA) begin errors++; $display("FAIL err_inst_bad: got %h expected %h", data_in_inst, BAD_DATA); end
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected %b", mem_err, 1'b1); end
      set_data(1'b1, 32'h0003_0000, 4'h0, '0); step();
      checks++; if (data_in_data !== BAD_DATA) begin errors++; $display("FAIL err_data_bad: got %h expected %h", data_in_data, BAD_DATA); end
      set_data(1'b1, MMIO_BASE + 32'd12, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h0002_0000) begin errors++; $display("FAIL err_addr_first: got %h expected %h", data_in_data, 32'h0002_0000); end
      set_data(1'b1, MMIO_BASE + 32'd8, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'd1) begin errors++; $display("FAIL err_status_read: got %h expected %h", data_in_data, 32'd1); end
      set_data(1'b1, MMIO_BASE + 32'd8, 4'b0001, 32'h1); step();
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_w1c: got %b expected %b", mem_err, 1'b0); end
      // Top RAM word is in range; one word past it is not and must not alias word 0
      set_data(1'b1, 32'h0, 4'hF, 32'h00C0_FFEE); step();
      set_data(1'b1, 32'hFFC, 4'hF, 32'hCAFE_F00D); step();
      set_data(1'b1, 32'hFFC, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_top_word: got %h expected %h", data_in_data, 32'hCAFE_F00D); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_top_in_range: got %b expected %b", mem_err, 1'b0); end
      set_data(1'b1, 32'h1000, 4'hF, 32'hBADB_AD00); step();
      set_data(1'b1, 32'h0, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h00C0_FFEE) begin errors++; $display("FAIL err_write_discarded: got %h expected %h", data_in_data, 32'h00C0_FFEE); end
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_past_end: got %b expected %b", mem_err, 1'b1); end
      set_data(1'b1, MMIO_BASE + 32'd8, 4'b0001, 32'h1); step();
      set_inst(1'b1, 32'h0004_0000, 4'h0, '0);
      set_data(1'b1, MMIO_BASE + 32'd16, 4'h0, '0); step();
      idle();
      set_data(1'b1, MMIO_BASE + 32'd12, 4'h0, '0); step();
      checks++; if (data_in_data !== MMIO_BASE + 32'd16) begin errors++; $display("FAIL err_both_ports: got %h expected %h", data_in_data, MMIO_BASE + 32'd16); end
      // Inst-port access to the MMIO window is an error; it beats a same-cycle clear
      set_inst(1'b1, MMIO_BASE, 4'h0, '0);
      set_data(1'b1, MMIO_BASE + 32'd8, 4'b0001, 32'h1); step();
      idle();
      checks++; if (data_in_inst !== BAD_DATA) begin errors++; $display("FAIL err_inst_mmio: got %h expected %h", data_in_inst, BAD_DATA); end
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_set_beats_clr: got %b expected %b", mem_err, 1'b1); end
      set_data(1'b1, MMIO_BASE - 32'd4, 4'h0, '0); step();
      set_data(1'b1, MMIO_BASE + 32'd12, 4'h0, '0); step();
      checks++; if (data_in_data !== MMIO_BASE) begin errors++; $display("FAIL err_recapture: got %h expected %h", data_in_data, MMIO_BASE); end
      idle();
   endtask

   task automatic test_reset_mid();
      set_data(1'b1, MMIO_BASE, 4'hF, 32'h0000_0077);
      set_inst(1'b1, 32'h0005_0000, 4'h0, '0); step();
      idle();
      checks++; if (gpio_out !== 32'h77 || mem_err !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got gpio %h err %b expected gpio %h err %b", gpio_out, mem_err, 32'h77, 1'b1); end
      // Read pending and an inst write queued for the edge that falls inside reset
      set_data(1'b1, 32'h10, 4'h0, '0);
      set_inst(1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF);
      #2 aresetn = 1'b0;
      #1;
      checks++; if (data_in_data !== 32'd0) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data_in_data, 32'd0); end
      checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL rstmid_gpio: got %h expected %h", gpio_out, 32'd0); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected %b", mem_err, 1'b0); end
      @(posedge aclk); #1;
      checks++; if (data_in_data !== 32'd0 || data_in_inst !== 32'd0) begin errors++; $display("FAIL rstmid_hold: got %h/%h expected %h", data_in_data, data_in_inst, 32'd0); end
      @(negedge aclk);
      idle();
      @(negedge aclk);
      model_reset();
      aresetn = 1'b1;
      set_data(1'b1, 32'h10, 4'h0, '0); step();
      checks++; if (data_in_data !== 32'h1234_5678) begin errors++; $display("FAIL rstmid_ram_kept: got %h expected %h", data_in_data, 32'h1234_5678); end
      idle();
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7) return ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if (r < 9) return MMIO_BASE + $urandom_range(0, 15);
      case ($urandom_range(0, 3))
         0:       return 32'h1000 + ($urandom_range(0, 7) << 2);
         1:       return MMIO_BASE + 32'd16;
         2:       return 32'hFFFF_FFFC;
         default: return MMIO_BASE - 32'd4;
      endcase
   endfunction

   task automatic test_random();
      for (int w = 0; w < 32; w++) begin
         set_data(1'b1, w * 4, 4'hF, $urandom); step();
      end
      for (int n = 0; n < 400; n++) begin
         set_inst(1'($urandom_range(0, 1)), rand_addr(),
                  $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
         set_data(1'($urandom_range(0, 1)), rand_addr(),
                  $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
         step();
         checks++; if (data_in_inst !== ref_inst_out) begin errors++; $display("FAIL rand_inst[%0d]: got %h expected %h", n, data_in_inst, ref_inst_out); end
         checks++; if (data_in_data !== ref_data_out) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, data_in_data, ref_data_out); end
         checks++; if (gpio_out !== ref_gpio) begin errors++; $display("FAIL rand_gpio[%0d]: got %h expected %h", n, gpio_out, ref_gpio); end
         checks++; if (mem_err !== ref_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, mem_err, ref_err); end
      end
      idle();
      set_data(1'b1, MMIO_BASE + 32'd12, 4'h0, '0); step();
      checks++; if (data_in_data !== ref_err_addr) begin errors++; $display("FAIL rand_err_addr: got %h expected %h", data_in_data, ref_err_addr); end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_basic();
      test_byte_lanes();
      test_dual_port();
      test_mmio();
      test_errors();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
